mult_div_unit: RTL

Parametrised iterative multiply/divide unit for the multicycle CPU datapath. It fills the MULT/DIV slot and feeds the Hi/Lo inputs of the memory-to-register mux.
- The control unit pulses start with an op code and holds the CPU in a wait state until done.
- Results are held in internal Hi/Lo registers until the next operation.
- Divide-by-zero is flagged so the control unit can take the exception path through EPC.

---
 rtl/mult_div_pkg.sv | 23 ++
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div_sign_fix.sv | 51 +++++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings
// and the controller state type.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_DIV   = 2'b01,
    OP_MULTU = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Both divide encodings have bit 0 set.
  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_sign_fix.sv
// Sign handling around the unsigned iterative core: converts operands to
// magnitudes on entry and applies two's-complement correction to the raw
// accumulator when the result is written back.
module mult_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_magA,
  output logic [WIDTH-1:0]   o_magB,
  output logic               o_negQ,
  output logic               o_negR,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic               i_isDiv,
  input  logic               i_negQ,
  input  logic               i_negR,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic               w_aNeg;
  logic               w_bNeg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_aNeg = i_signed & i_a[WIDTH-1];
  assign w_bNeg = i_signed & i_b[WIDTH-1];

  assign o_magA = w_aNeg ? -i_a : i_a;
  assign o_magB = w_bNeg ? -i_b : i_b;
  assign o_negQ = w_aNeg ^ w_bNeg;
  assign o_negR = w_aNeg;

  assign w_prod = i_negQ ? -i_acc : i_acc;
  assign w_quot = i_negQ ? -i_acc[WIDTH-1:0] : i_acc[WIDTH-1:0];
  assign w_rem  = i_negR ? -i_acc[2*WIDTH-1:WIDTH] : i_acc[2*WIDTH-1:WIDTH];

  // A product is negated as one double-width value; quotient and remainder
  // carry independent signs.
  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (i_isDiv) begin
      o_hi = w_rem;
      o_lo = w_quot;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on a double-width accumulator, results kept in hi/lo.
// Build macro MULT_DIV_UNSIGNED_EN enables MULTU/DIVU; without it op[1] is
// ignored and every op is treated as signed.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mult_div_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_magB;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;
  logic               r_zero;
  logic               r_busy;
  logic               r_done;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_negQ;
  logic               w_negR;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH-1:0]   w_divDiff;
  logic               w_divFits;
  logic [2*WIDTH-1:0] w_nextAcc;

`ifdef MULT_DIV_UNSIGNED_EN
  assign w_signed = ~bus.op[1];
`else
  assign w_signed = 1'b1;
`endif

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_signFix (
    .i_signed (w_signed),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_magA   (w_magA),
    .o_magB   (w_magB),
    .o_negQ   (w_negQ),
    .o_negR   (w_negR),
    .i_acc    (r_acc),
    .i_isDiv  (r_isDiv),
    .i_negQ   (r_negQ),
    .i_negR   (r_negR),
    .o_hi     (w_fixHi),
    .o_lo     (w_fixLo)
  );

  assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_magB};
  assign w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_divFits  = w_divShift >= {1'b0, r_magB};
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_magB;

  // One iteration: multiply adds the multiplicand into the upper half and
  // shifts right; divide shifts left and keeps the trial subtraction if it fits.
  always_comb begin
    w_nextAcc = {1'b0, r_acc[2*WIDTH-1:1]};
    if (r_isDiv) begin
      if (w_divFits) w_nextAcc = {w_divDiff, r_acc[WIDTH-2:0], 1'b1};
      else           w_nextAcc = {r_acc[2*WIDTH-2:0], 1'b0};
    end else if (r_acc[0]) begin
      w_nextAcc = {w_mulSum, r_acc[WIDTH-1:1]};
    end
  end

  // Controller: accept a request in IDLE, iterate WIDTH steps, then write back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_magB    <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_isDiv <= is_div(bus.op);
            r_negQ  <= w_negQ;
            r_negR  <= w_negR;
            r_magB  <= w_magB;
            r_acc   <= {{WIDTH{1'b0}}, w_magA};
            r_count <= '0;
            r_busy  <= 1'b1;
            if (is_div(bus.op) && (bus.b == '0)) begin
              r_zero  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_zero  <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc   <= w_nextAcc;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) r_state <= FIN;
        end
        FIN: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_divZero <= r_zero;
          if (!r_zero) begin
            r_hi <= w_fixHi;
            r_lo <= w_fixLo;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_divZero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule
